perf_run_ctrl: RTL and testbench

Run controller and performance-measurement sequencer for the 5-stage pipelined core.
- Holds the core in reset until commanded, releases it, and gates its run enable while a program executes.
- Stops on a halt instruction or an instruction budget.
- Accumulates cycle, instruction, branch and branch-mispredict counts from pipeline taps (IF instruction word, EX/MEM branch flag, IF flush) for predictor comparison.
- Sits beside the core in the simulation/FPGA top; exposes counters through a registered read port.

---
 rtl/perf_run_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_perf_run_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_run_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : perf_run_ctrl
// Brief   : Core run sequencer with saturating cycle/insn/branch/miss counters.
// Rev     : 1.0  initial release
// =============================================================================
module perf_run_ctrl #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_INSN = 32'h0010_0073,
    parameter int          RST_CYC   = 4,
    parameter int          DRAIN_CYC = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] max_insn_i,
    input  logic             insn_vld_i,
    input  logic [31:0]      instr_i,
    input  logic             br_instr_i,
    input  logic             br_miss_i,
    output logic             core_rst_no,
    output logic             run_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o,
    input  logic [1:0]       rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o
);

    localparam int SEQ_MAX = (RST_CYC > DRAIN_CYC) ? RST_CYC : DRAIN_CYC;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

    localparam logic [SEQ_W-1:0] SEQ_RST   = SEQ_W'(RST_CYC - 1);
    localparam logic [SEQ_W-1:0] SEQ_DRAIN = SEQ_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_CORE = 3'd1,
        ST_RUN        = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

    state_e           state_q;
    logic [SEQ_W-1:0] seq_q;
    logic [CNT_W-1:0] budget_q;
    logic             core_rst_n_q;
    logic             run_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] cyc_q,  cyc_d;
    logic [CNT_W-1:0] insn_q, insn_d;
    logic [CNT_W-1:0] br_q,   br_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             ovf_q,  ovf_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic w_start_acc;
    logic w_cnt_en;
    logic w_insn_en;
    logic w_sat_hit;
    logic w_halt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    // Abort takes priority over everything, including a coincident start.
    assign w_start_acc = start_i && !abort_i &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_cnt_en    = !abort_i && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign w_insn_en   = !abort_i && (state_q == ST_RUN) && insn_vld_i;

    assign w_sat_hit = (w_cnt_en && (&cyc_q)) ||
                       (w_insn_en && (&insn_q)) ||
                       (w_cnt_en && br_instr_i && (&br_q)) ||
                       (w_cnt_en && br_miss_i && (&miss_q));

    // Budget compares against the post-increment count so the Nth insn halts.
    assign w_halt = (state_q == ST_RUN) &&
                    ((insn_vld_i && (instr_i == HALT_INSN)) ||
                     ((budget_q != '0) && (insn_d == budget_q)));

    always_comb begin
        cyc_d  = cyc_q;
        insn_d = insn_q;
        br_d   = br_q;
        miss_d = miss_q;
        ovf_d  = ovf_q;
        if (w_start_acc) begin
            cyc_d  = '0;
            insn_d = '0;
            br_d   = '0;
            miss_d = '0;
            ovf_d  = 1'b0;
        end else begin
            cyc_d  = sat_inc(cyc_q,  w_cnt_en);
            insn_d = sat_inc(insn_q, w_insn_en);
            br_d   = sat_inc(br_q,   w_cnt_en && br_instr_i);
            miss_d = sat_inc(miss_q, w_cnt_en && br_miss_i);
            ovf_d  = ovf_q | w_sat_hit;
        end
    end

    always_comb begin
        rd_data_d = cyc_q;
        unique case (rd_sel_i)
            2'd0:    rd_data_d = cyc_q;
            2'd1:    rd_data_d = insn_q;
            2'd2:    rd_data_d = br_q;
            default: rd_data_d = miss_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q     <= '0;
            insn_q    <= '0;
            br_q      <= '0;
            miss_q    <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            cyc_q     <= cyc_d;
            insn_q    <= insn_d;
            br_q      <= br_d;
            miss_q    <= miss_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            seq_q        <= '0;
            budget_q     <= '0;
            core_rst_n_q <= 1'b0;
            run_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (abort_i) begin
            state_q      <= ST_IDLE;
            core_rst_n_q <= 1'b0;
            run_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q      <= ST_RESET_CORE;
                        seq_q        <= SEQ_RST;
                        budget_q     <= max_insn_i;
                        core_rst_n_q <= 1'b0;
                        run_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                    end
                end
                ST_RESET_CORE: begin
                    if (seq_q == '0) begin
                        state_q      <= ST_RUN;
                        core_rst_n_q <= 1'b1;
                        run_q        <= 1'b1;
                    end else begin
                        seq_q <= seq_q - SEQ_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_halt) begin
                        state_q <= ST_DRAIN;
                        seq_q   <= SEQ_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (seq_q == '0) begin
                        state_q <= ST_DONE;
                        run_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        seq_q <= seq_q - SEQ_W'(1);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    core_rst_n_q <= 1'b0;
                    run_q        <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_no = core_rst_n_q;
    assign run_o       = run_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;
    assign rd_data_o   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_run_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_perf_run_ctrl
// Brief   : Table vectors, directed corner runs and random programs vs a model.
// Rev     : 1.0  initial release
// =============================================================================
module tb_perf_run_ctrl;

    localparam logic [31:0] HALT      = 32'h0010_0073;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam int          RST_CYC   = 4;
    localparam int          DRAIN_CYC = 3;

    logic        clk_i, rst_ni, start_i, abort_i;
    logic [31:0] max_insn_i;
    logic        insn_vld_i;
    logic [31:0] instr_i;
    logic        br_instr_i, br_miss_i;
    logic [1:0]  rd_sel_i;
    logic        core_rst_no, run_o, busy_o, done_o, ovf_o;
    logic [31:0] rd_data_o;

    logic [3:0]  max4;
    logic        core_rst_n4, run_4, busy_4, done_4, ovf_4;
    logic [3:0]  rd_data4;

    int n_chk = 0;
    int n_err = 0;

    perf_run_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .max_insn_i(max_insn_i), .insn_vld_i(insn_vld_i), .instr_i(instr_i),
        .br_instr_i(br_instr_i), .br_miss_i(br_miss_i), .core_rst_no(core_rst_no),
        .run_o(run_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o)
    );

    // Narrow instance shares the stimulus; it only exists to exercise saturation.
    perf_run_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .max_insn_i(max4), .insn_vld_i(insn_vld_i), .instr_i(instr_i),
        .br_instr_i(br_instr_i), .br_miss_i(br_miss_i), .core_rst_no(core_rst_n4),
        .run_o(run_4), .busy_o(busy_4), .done_o(done_4), .ovf_o(ovf_4),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data4)
    );

    always_comb max4 = (max_insn_i > 32'd15) ? 4'd15 : max_insn_i[3:0];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        start, abort, vld;
        logic [31:0] instr;
        logic        br, miss;
        logic [1:0]  sel;
        logic        rstn, run, busy, done;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic        br, miss;
    } stim_t;

    vec_t  vq[$];
    stim_t prog[$];

    function automatic vec_t mk(input int st, input int ab, input int vl, input logic [31:0] ins,
                                input int b, input int m, input int sel, input int rn, input int rr,
                                input int bz, input int dn, input int ck, input int er);
        vec_t v;
        v.start = (st != 0); v.abort = (ab != 0); v.vld = (vl != 0); v.instr = ins;
        v.br = (b != 0); v.miss = (m != 0); v.sel = 2'(sel);
        v.rstn = (rn != 0); v.run = (rr != 0); v.busy = (bz != 0); v.done = (dn != 0);
        v.chk_rd = (ck != 0); v.exp_rd = 32'(er);
        return v;
    endfunction

    function automatic stim_t ms(input int vl, input logic [31:0] ins, input int b, input int m);
        stim_t s;
        s.vld = (vl != 0); s.instr = ins; s.br = (b != 0); s.miss = (m != 0);
        return s;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_in();
        start_i = 1'b0; abort_i = 1'b0; insn_vld_i = 1'b0;
        instr_i = NOP; br_instr_i = 1'b0; br_miss_i = 1'b0;
    endtask

    task automatic apply(input stim_t s);
        insn_vld_i = s.vld; instr_i = s.instr; br_instr_i = s.br; br_miss_i = s.miss;
    endtask

    task automatic read_cnt(input int sel, output logic [31:0] v);
        rd_sel_i = 2'(sel);
        step();
        v = rd_data_o;
    endtask

    // Expected results derived straight from the program: find the halting
    // cycle, then count events over the run plus the drain window.
    function automatic void model(input logic [31:0] budget, output int h, output int ei,
                                  output int ec, output int eb, output int em);
        int n;
        n = 0;
        h = -1;
        for (int i = 0; i < prog.size(); i++) begin
            if (prog[i].vld) n++;
            if ((prog[i].vld && prog[i].instr == HALT) || (budget != 0 && n == budget)) begin
                h = i;
                break;
            end
        end
        if (h < 0) h = prog.size() - 1;
        ei = n;
        ec = h + 1 + DRAIN_CYC;
        eb = 0;
        em = 0;
        for (int i = 0; i < ec && i < prog.size(); i++) begin
            if (prog[i].br) eb++;
            if (prog[i].miss) em++;
        end
    endfunction

    task automatic run_prog(input logic [31:0] budget, input string tag);
        int h, ei, ec, eb, em, dn;
        logic early;
        logic [31:0] v;
        model(budget, h, ei, ec, eb, em);
        dn = h + DRAIN_CYC;
        clear_in();
        start_i = 1'b1; max_insn_i = budget; rd_sel_i = 2'd1;
        step();
        start_i = 1'b0;
        chk1({tag, " rst_n at start"}, core_rst_no, 1'b0);
        chk1({tag, " busy at start"}, busy_o, 1'b1);
        chk1({tag, " ovf cleared"}, ovf_o, 1'b0);
        chk1({tag, " ovf4 cleared"}, ovf_4, 1'b0);
        for (int k = 1; k < RST_CYC; k++) begin
            step();
            chk1({tag, " rst_n held"}, core_rst_no, 1'b0);
            chk1({tag, " run held"}, run_o, 1'b0);
        end
        chk32({tag, " insn cleared"}, rd_data_o, 32'd0);
        step();
        chk1({tag, " rst_n release"}, core_rst_no, 1'b1);
        chk1({tag, " run release"}, run_o, 1'b1);
        early = 1'b0;
        for (int i = 0; i <= dn; i++) begin
            if (i < prog.size()) apply(prog[i]);
            else clear_in();
            step();
            if (i < dn && done_o) early = 1'b1;
            if (i == h) begin
                chk1({tag, " run in drain"}, run_o, 1'b1);
                chk1({tag, " busy in drain"}, busy_o, 1'b1);
            end
        end
        chk1({tag, " early done"}, early, 1'b0);
        chk1({tag, " done"}, done_o, 1'b1);
        chk1({tag, " run in done"}, run_o, 1'b0);
        chk1({tag, " rst_n in done"}, core_rst_no, 1'b1);
        chk1({tag, " busy in done"}, busy_o, 1'b0);
        clear_in();
        read_cnt(0, v); chk32({tag, " cycles"}, v, 32'(ec));
        read_cnt(1, v); chk32({tag, " insn"}, v, 32'(ei));
        read_cnt(2, v); chk32({tag, " br"}, v, 32'(eb));
        read_cnt(3, v); chk32({tag, " miss"}, v, 32'(em));
        chk1({tag, " ovf"}, ovf_o, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] prev;
        logic [31:0] rp_exp[4];
        int len;
        logic [31:0] bud;

        // Directed run: reset, start, 10 insns with branches, halt, drain.
        vq.push_back(mk(1, 0, 0, NOP,  0, 0, 0,  0, 0, 1, 0,  1, 0));
        vq.push_back(mk(0, 0, 0, NOP,  0, 0, 1,  0, 0, 1, 0,  0, 0));
        vq.push_back(mk(0, 0, 0, NOP,  0, 0, 2,  0, 0, 1, 0,  1, 0));
        vq.push_back(mk(0, 0, 0, NOP,  0, 0, 3,  0, 0, 1, 0,  1, 0));
        vq.push_back(mk(0, 0, 0, NOP,  0, 0, 0,  1, 1, 1, 0,  1, 0));
        for (int r = 5; r <= 14; r++)
            vq.push_back(mk((r == 7) ? 1 : 0, 0, 1, NOP,
                            (r == 6 || r == 8 || r == 10) ? 1 : 0, (r == 9) ? 1 : 0, 0,
                            1, 1, 1, 0, 1, r - 5));
        vq.push_back(mk(0, 0, 1, HALT, 0, 0, 1,  1, 1, 1, 0,  1, 10));
        vq.push_back(mk(0, 0, 0, NOP,  0, 1, 1,  1, 1, 1, 0,  1, 11));
        vq.push_back(mk(1, 0, 0, NOP,  0, 0, 3,  1, 1, 1, 0,  1, 2));
        vq.push_back(mk(0, 0, 0, NOP,  0, 0, 2,  1, 0, 0, 1,  1, 3));

        rst_ni = 1'b0;
        clear_in();
        max_insn_i = 32'd0;
        rd_sel_i = 2'd0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        chk1("reset core_rst_no", core_rst_no, 1'b0);
        chk1("reset run", run_o, 1'b0);
        chk1("reset busy", busy_o, 1'b0);
        chk1("reset done", done_o, 1'b0);
        chk1("reset ovf", ovf_o, 1'b0);
        chk32("reset rd_data", rd_data_o, 32'd0);

        foreach (vq[i]) begin
            start_i = vq[i].start; abort_i = vq[i].abort; insn_vld_i = vq[i].vld;
            instr_i = vq[i].instr; br_instr_i = vq[i].br; br_miss_i = vq[i].miss;
            rd_sel_i = vq[i].sel;
            step();
            chk1($sformatf("vec%0d rst_n", i), core_rst_no, vq[i].rstn);
            chk1($sformatf("vec%0d run", i), run_o, vq[i].run);
            chk1($sformatf("vec%0d busy", i), busy_o, vq[i].busy);
            chk1($sformatf("vec%0d done", i), done_o, vq[i].done);
            if (vq[i].chk_rd) chk32($sformatf("vec%0d rd", i), rd_data_o, vq[i].exp_rd);
        end
        clear_in();

        // Read port latency in DONE: old value until the edge, new one after.
        rp_exp[0] = 32'd14; rp_exp[1] = 32'd11; rp_exp[2] = 32'd3; rp_exp[3] = 32'd2;
        prev = 32'd3;
        for (int s = 0; s < 4; s++) begin
            rd_sel_i = 2'(s);
            #1;
            chk32($sformatf("rd sel%0d before edge", s), rd_data_o, prev);
            step();
            chk32($sformatf("rd sel%0d", s), rd_data_o, rp_exp[s]);
            prev = rp_exp[s];
        end

        prog.delete();
        for (int i = 0; i < 12; i++) prog.push_back(ms(1, NOP, (i % 3 == 0) ? 1 : 0, 0));
        run_prog(32'd5, "budget5");

        prog.delete();
        for (int i = 0; i < 4; i++) prog.push_back(ms(1, NOP, 0, (i == 1) ? 1 : 0));
        prog.push_back(ms(1, HALT, 1, 0));
        for (int i = 0; i < 6; i++) prog.push_back(ms(1, NOP, 1, 1));
        run_prog(32'd5, "halt_is_5th");

        prog.delete();
        prog.push_back(ms(0, HALT, 1, 0));
        prog.push_back(ms(0, NOP, 0, 1));
        for (int i = 0; i < 6; i++) prog.push_back(ms(1, NOP, 1, 0));
        run_prog(32'd1, "budget1");

        // Abort mid-RUN with a coincident start and coincident events.
        clear_in();
        start_i = 1'b1; max_insn_i = 32'd0;
        step();
        start_i = 1'b0;
        repeat (RST_CYC) step();
        chk1("abort pre run", run_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply(ms(1, NOP, (i % 2 == 0) ? 1 : 0, 0));
            step();
        end
        start_i = 1'b1; abort_i = 1'b1; apply(ms(1, NOP, 1, 1));
        step();
        clear_in();
        chk1("abort rst_n", core_rst_no, 1'b0);
        chk1("abort run", run_o, 1'b0);
        chk1("abort busy", busy_o, 1'b0);
        chk1("abort done", done_o, 1'b0);
        step();
        chk1("abort stays idle", busy_o, 1'b0);
        read_cnt(0, v); chk32("abort cycles", v, 32'd6);
        read_cnt(1, v); chk32("abort insn", v, 32'd6);
        read_cnt(2, v); chk32("abort br", v, 32'd3);
        read_cnt(3, v); chk32("abort miss", v, 32'd0);
        chk1("abort done after reads", done_o, 1'b0);

        // 20 RUN cycles saturate the 4-bit instance only.
        prog.delete();
        for (int i = 0; i < 19; i++) prog.push_back(ms(0, NOP, 0, 0));
        prog.push_back(ms(1, HALT, 0, 0));
        run_prog(32'd0, "sat");
        rd_sel_i = 2'd0;
        step();
        chk32("sat cycles4", 32'(rd_data4), 32'd15);
        chk1("sat ovf4", ovf_4, 1'b1);
        chk1("sat done4", done_4, 1'b1);

        for (int r = 0; r < 10; r++) begin
            prog.delete();
            len = $urandom_range(30, 3);
            for (int i = 0; i < len - 1; i++) begin
                prog.push_back(ms(($urandom % 4 != 0) ? 1 : 0,
                                  ($urandom % 16 == 0) ? HALT : NOP,
                                  ($urandom % 3 == 0) ? 1 : 0,
                                  ($urandom % 5 == 0) ? 1 : 0));
            end
            prog.push_back(ms(1, HALT, 0, 0));
            for (int i = 0; i < DRAIN_CYC; i++)
                prog.push_back(ms($urandom % 2, NOP, $urandom % 2, $urandom % 2));
            bud = ($urandom % 2 == 0) ? 32'd0 : 32'($urandom_range(len, 1));
            run_prog(bud, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
